// File: rtl/systolic_feeder_ws.sv
// Edge sequencer for a weight-stationary systolic array: preloads weight rows,
// then streams row-skewed activation vectors and drains with zero bubbles.
module systolic_feeder_ws #(
    parameter int unsigned WORDWIDTH = 8,
    parameter int unsigned ROWS      = 4,
    parameter int unsigned COLS      = 4,
    parameter int unsigned CNTWIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [CNTWIDTH-1:0]       num_vectors,
    input  logic                      w_valid,
    output logic                      w_ready,
    input  logic [WORDWIDTH*COLS-1:0] w_data,
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic [WORDWIDTH*ROWS-1:0] a_data,
    output logic                      mode,
    output logic                      w_shift,
    output logic [WORDWIDTH*COLS-1:0] w_out,
    output logic [ROWS-1:0]           enable_out,
    output logic [WORDWIDTH*ROWS-1:0] a_out,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned DRAIN_LEN = ROWS + COLS - 1;
    localparam int unsigned DW        = $clog2(DRAIN_LEN + 1);
    localparam int unsigned BW        = $clog2(ROWS + 1);

    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

    state_t              state, next_state;
    logic [CNTWIDTH-1:0] nv_q, acc_cnt;
    logic [BW-1:0]       beat_cnt;
    logic [DW-1:0]       drain_cnt;

    logic w_acc, a_acc, last_beat, last_vec, drain_last, zero_job;

    logic                      w_ready_d, a_ready_d, mode_d, w_shift_d, busy_d, done_d;
    logic [WORDWIDTH*COLS-1:0] w_out_d;

    assign w_acc      = w_valid && w_ready && (state == LOAD_W);
    assign a_acc      = a_valid && a_ready && (state == STREAM);
    assign last_beat  = w_acc && (beat_cnt == BW'(ROWS - 1));
    assign last_vec   = a_acc && (acc_cnt == nv_q - CNTWIDTH'(1));
    assign drain_last = (drain_cnt == DW'(DRAIN_LEN - 1));
    assign zero_job   = (state == IDLE) && start && (num_vectors == '0);

    // State register and per-state counters (cleared whenever their state is left)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            nv_q      <= '0;
            acc_cnt   <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            state <= next_state;
            if ((state == IDLE) && start && (num_vectors != '0))
                nv_q <= num_vectors;
            beat_cnt  <= (state != LOAD_W) ? '0 : (w_acc ? beat_cnt + BW'(1) : beat_cnt);
            acc_cnt   <= (state != STREAM) ? '0 : (a_acc ? acc_cnt + CNTWIDTH'(1) : acc_cnt);
            drain_cnt <= (state != DRAIN)  ? '0 : drain_cnt + DW'(1);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start && (num_vectors != '0)) next_state = LOAD_W;
            LOAD_W:  if (last_beat)  next_state = STREAM;
            STREAM:  if (last_vec)   next_state = DRAIN;
            DRAIN:   if (drain_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // mode lags the LOAD_W->STREAM transition so the last weight shift sees mode=0
    always_comb begin
        w_ready_d = 1'b0;
        a_ready_d = 1'b0;
        mode_d    = 1'b0;
        w_shift_d = 1'b0;
        w_out_d   = '0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        w_ready_d = (next_state == LOAD_W);
        a_ready_d = (next_state == STREAM);
        mode_d    = ((state == STREAM) && (next_state == STREAM)) || (next_state == DRAIN);
        w_shift_d = w_acc;
        w_out_d   = w_acc ? w_data : '0;
        busy_d    = (next_state != IDLE);
        done_d    = zero_job || ((state == DRAIN) && drain_last);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            w_ready <= 1'b0;
            a_ready <= 1'b0;
            mode    <= 1'b0;
            w_shift <= 1'b0;
            w_out   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            w_ready <= w_ready_d;
            a_ready <= a_ready_d;
            mode    <= mode_d;
            w_shift <= w_shift_d;
            w_out   <= w_out_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Row r: common input stage plus r delay stages; idle cycles inject bubbles
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [WORDWIDTH-1:0] sd [r+1];
        logic                 se [r+1];

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                for (int k = 0; k <= r; k++) begin
                    sd[k] <= '0;
                    se[k] <= 1'b0;
                end
            end else begin
                sd[0] <= a_acc ? a_data[r*WORDWIDTH +: WORDWIDTH] : '0;
                se[0] <= a_acc;
                for (int k = 1; k <= r; k++) begin
                    sd[k] <= sd[k-1];
                    se[k] <= se[k-1];
                end
            end
        end

        assign a_out[r*WORDWIDTH +: WORDWIDTH] = sd[r];
        assign enable_out[r]                   = se[r];
    end

endmodule

// File: tb/tb_systolic_feeder_ws.sv
// Directed bench for systolic_feeder_ws with a timestamped scoreboard for
// weight rows and per-row skewed activation elements.
module tb_systolic_feeder_ws;

    localparam int unsigned W  = 8;
    localparam int unsigned R  = 4;
    localparam int unsigned C  = 4;
    localparam int unsigned CW = 16;

    logic            clk, reset_n, start, w_valid, a_valid;
    logic [CW-1:0]   num_vectors;
    logic [W*C-1:0]  w_data, w_out;
    logic [W*R-1:0]  a_data, a_out;
    logic            w_ready, a_ready, mode, w_shift, busy, done;
    logic [R-1:0]    enable_out;

    systolic_feeder_ws #(.WORDWIDTH(W), .ROWS(R), .COLS(C), .CNTWIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_vectors(num_vectors),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .mode(mode), .w_shift(w_shift), .w_out(w_out),
        .enable_out(enable_out), .a_out(a_out), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [W*C-1:0] data; int due; } w_item_t;
    typedef struct { int unsigned row; logic [W-1:0] data; int due; } a_item_t;

    w_item_t wq[$];
    a_item_t aq[$];
    int cyc = 0, n_assert = 0, n_fail = 0, done_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record accepted beats as expectations, then check outputs due now
    task automatic tick();
        logic           w_acc, a_acc, rst_s, exp_ws;
        logic [W*C-1:0] exp_wo;
        logic [R-1:0]   exp_en;
        logic [W*R-1:0] exp_ao;
        w_acc = (w_valid === 1'b1) && (w_ready === 1'b1);
        a_acc = (a_valid === 1'b1) && (a_ready === 1'b1);
        rst_s = !reset_n;
        if (!rst_s) begin
            if (w_acc) wq.push_back('{data: w_data, due: cyc + 1});
            if (a_acc)
                for (int r = 0; r < R; r++)
                    aq.push_back('{row: r, data: a_data[r*W +: W], due: cyc + 1 + r});
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst_s) begin
            wq.delete();
            aq.delete();
        end
        if (done === 1'b1) done_cnt++;
        exp_ws = 1'b0;
        exp_wo = '0;
        if (wq.size() > 0 && wq[0].due == cyc) begin
            exp_ws = 1'b1;
            exp_wo = wq[0].data;
            void'(wq.pop_front());
        end
        chk("w_shift", 64'(w_shift), 64'(exp_ws));
        chk("w_out", 64'(w_out), 64'(exp_wo));
        exp_en = '0;
        exp_ao = '0;
        for (int i = aq.size() - 1; i >= 0; i--) begin
            if (aq[i].due == cyc) begin
                exp_en[aq[i].row]         = 1'b1;
                exp_ao[aq[i].row*W +: W]  = aq[i].data;
                aq.delete(i);
            end
        end
        chk("enable_out", 64'(enable_out), 64'(exp_en));
        chk("a_out", 64'(a_out), 64'(exp_ao));
    endtask

    task automatic start_job(input logic [CW-1:0] nv);
        start       = 1'b1;
        num_vectors = nv;
        tick();
        start       = 1'b0;
        chk("job_busy", 64'(busy), 64'(1));
        chk("job_w_ready", 64'(w_ready), 64'(1));
    endtask

    // Four consecutive beats: base, base+0x04040404, ...
    task automatic load_w(input logic [31:0] base);
        w_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_data = base + 32'(i) * 32'h04040404;
            tick();
            chk("load_w_shift", 64'(w_shift), 64'(1));
            chk("load_mode0", 64'(mode), 64'(0));
        end
        w_valid = 1'b0;
        w_data  = '0;
        chk("stream_a_ready", 64'(a_ready), 64'(1));
    endtask

    task automatic wait_done(output int at);
        for (int i = 0; i < 40 && done !== 1'b1; i++) tick();
        chk("done_seen", 64'(done), 64'(1));
        chk("busy_at_done", 64'(busy), 64'(0));
        at = cyc;
    endtask

    initial begin
        int c1, c3, t_done, d0;
        logic [3:0] hist;
        logic [3:0] pat;

        reset_n = 1'b0; start = 1'b0; num_vectors = '0;
        w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
        tick();
        tick();
        chk("reset_ctrl", 64'({busy, done, mode, w_ready, a_ready, w_shift}), 64'(0));
        reset_n = 1'b1;
        tick();
        chk("idle_ctrl", 64'({busy, done, mode, w_ready, a_ready}), 64'(0));

        // Weight load and single-vector skew walk
        start_job(16'd1);
        chk("loadw_mode", 64'(mode), 64'(0));
        load_w(32'h04030201);
        a_valid = 1'b1;
        a_data  = 32'h05040302;
        tick();
        a_valid = 1'b0;
        a_data  = '0;
        c1 = cyc;
        chk("mode_after_last_shift", 64'(mode), 64'(1));
        chk("a_ready_after_last", 64'(a_ready), 64'(0));
        chk("skew_en_0", 64'(enable_out), 64'(1));
        chk("skew_row0", 64'(a_out[7:0]), 64'(2));
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("skew_en_walk", 64'(enable_out), 64'(1) << k);
            chk("skew_row_data", 64'(a_out[k*W +: W]), 64'(k + 2));
        end
        wait_done(t_done);
        chk("drain_len_1", 64'(t_done - c1), 64'(7));
        tick();
        chk("done_pulse_1", 64'(done), 64'(0));

        // Bubbles and backpressure
        d0 = done_cnt;
        start_job(16'd3);
        load_w(32'h11223344);
        pat = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            a_valid = pat[i];
            a_data  = 32'hA0A1A2A3 + 32'(i);
            tick();
            hist[i] = enable_out[0];
            chk("bubble_a_ready", 64'(a_ready), (i == 3) ? 64'(0) : 64'(1));
        end
        a_valid = 1'b0;
        c3 = cyc;
        chk("bubble_en0_pattern", 64'(hist), 64'(4'b1101));
        wait_done(t_done);
        chk("drain_len_3", 64'(t_done - c3), 64'(7));
        tick();
        tick();
        chk("done_once", 64'(done_cnt - d0), 64'(1));

        // Zero-length job
        start       = 1'b1;
        num_vectors = '0;
        tick();
        start = 1'b0;
        chk("zero_done", 64'(done), 64'(1));
        chk("zero_busy", 64'(busy), 64'(0));
        chk("zero_w_ready", 64'(w_ready), 64'(0));
        tick();
        chk("zero_done_low", 64'(done), 64'(0));
        chk("zero_idle", 64'({busy, w_ready}), 64'(0));

        // start during STREAM must be ignored
        start_job(16'd2);
        load_w(32'h01010101);
        a_valid = 1'b1;
        a_data  = 32'h0D0C0B0A;
        tick();
        a_valid     = 1'b0;
        start       = 1'b1;
        num_vectors = 16'd5;
        tick();
        start = 1'b0;
        chk("ign_busy", 64'(busy), 64'(1));
        chk("ign_a_ready", 64'(a_ready), 64'(1));
        chk("ign_w_ready", 64'(w_ready), 64'(0));
        chk("ign_mode", 64'(mode), 64'(1));
        a_valid = 1'b1;
        a_data  = 32'h1D1C1B1A;
        tick();
        a_valid = 1'b0;
        chk("ign_nv_kept", 64'(a_ready), 64'(0));
        wait_done(t_done);
        tick();

        // Reset in the middle of STREAM
        start_job(16'd5);
        load_w(32'h20212223);
        a_valid = 1'b1;
        a_data  = 32'h33323130;
        tick();
        a_data  = 32'h43424140;
        tick();
        a_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("rst_ctrl", 64'({busy, done, mode, w_ready, a_ready, w_shift}), 64'(0));
        chk("rst_en", 64'(enable_out), 64'(0));
        chk("rst_a_out", 64'(a_out), 64'(0));
        start_job(16'd1);
        load_w(32'h50515253);
        a_valid = 1'b1;
        a_data  = 32'h63626160;
        tick();
        a_valid = 1'b0;
        wait_done(t_done);
        tick();
        tick();
        chk("sb_empty", 64'(wq.size() + aq.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
